soc_error_collector: RTL

- Central error-report collector behind the ERROR_REPORT APB window (0xF200_0000).
- Accepts per-source error reports, one per source per handshake, with fields matching the SoC error_info_t / error_type_t encoding. Arbitrates between sources round-robin and buffers accepted reports in an in-order FIFO.
- Drives the IRQ_ERROR (index 30) interrupt line and a sticky fatal flag for the safety island.
- Downstream APB register slave pops entries through a valid/ready port.

---
 rtl/soc_error_collector.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/soc_error_collector.sv
// Error-report collector: round-robin over sources into an in-order FIFO; drives IRQ_ERROR and a sticky fatal flag.
// Latency: a report accepted at edge T is at the head after T. Backpressure: all src_ready low when full and not popping.
// Optional macro ERR_COLLECTOR_TIMESTAMP_EN adds a free-running cycle stamp per entry on out_ts.
module soc_error_collector #(
  parameter int NUM_SRC    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [4*NUM_SRC-1:0]      src_type,
  input  logic [ADDR_W*NUM_SRC-1:0] src_addr,
  input  logic [8*NUM_SRC-1:0]      src_master,
  input  logic [NUM_SRC-1:0]        src_fatal,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_type,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [7:0]                out_master,
  output logic                      out_fatal,
  output logic [SRC_W-1:0]          out_src,
  output logic [CNT_W-1:0]          fill_level,
  output logic                      fatal_sticky,
  input  logic                      fatal_clr,
  output logic                      irq_err
`ifdef ERR_COLLECTOR_TIMESTAMP_EN
  ,
  output logic [31:0]               out_ts
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] ERR_NONE  = 4'h0;
  localparam logic [3:0] ERR_FATAL = 4'hF;

  typedef struct packed {
    logic [3:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        master;
    logic              fatal;
    logic [SRC_W-1:0]  src;
`ifdef ERR_COLLECTOR_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  entry_t           g_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [SRC_W-1:0] rr_ptr;
  logic             sticky;
  logic             hi_vld, lo_vld;
  logic [SRC_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic             head_vld, space, accept, push, pop, fatal_set;
`ifdef ERR_COLLECTOR_TIMESTAMP_EN
  logic [31:0]      ts_cnt;
`endif

  // Descending scan: the last hit is the lowest index, both overall and at/after rr_ptr.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        lo_vld = 1'b1;
        lo_idx = SRC_W'(i);
        if (SRC_W'(i) >= rr_ptr) begin
          hi_vld = 1'b1;
          hi_idx = SRC_W'(i);
        end
      end
    end
  end

  assign gnt_idx  = hi_vld ? hi_idx : lo_idx;
  assign head_vld = (cnt != '0) & ~rst;
  assign pop      = head_vld & out_ready;
  assign space    = (cnt < CNT_W'(FIFO_DEPTH)) | pop;
  assign accept   = lo_vld & space & ~rst;

  always_comb begin
    g_ent = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        g_ent.typ    = src_type[4*i +: 4];
        g_ent.addr   = src_addr[ADDR_W*i +: ADDR_W];
        g_ent.master = src_master[8*i +: 8];
        g_ent.fatal  = src_fatal[i];
      end
    end
    g_ent.src = gnt_idx;
`ifdef ERR_COLLECTOR_TIMESTAMP_EN
    g_ent.ts = ts_cnt;
`endif
  end

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = accept & (gnt_idx == SRC_W'(i));
    end
  end

  // ERR_NONE is handshaken but leaves no trace: no entry, no pointer move, no fatal.
  assign push      = accept & (g_ent.typ != ERR_NONE);
  assign fatal_set = push & (g_ent.fatal | (g_ent.typ == ERR_FATAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      sticky <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (fatal_set) begin
        sticky <= 1'b1;
      end else if (fatal_clr) begin
        sticky <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= g_ent;
    end
  end

`ifdef ERR_COLLECTOR_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end
`endif

  assign head         = mem[rd_ptr];
  assign out_valid    = head_vld;
  assign out_type     = head_vld ? head.typ    : '0;
  assign out_addr     = head_vld ? head.addr   : '0;
  assign out_master   = head_vld ? head.master : '0;
  assign out_fatal    = head_vld ? head.fatal  : 1'b0;
  assign out_src      = head_vld ? head.src    : '0;
`ifdef ERR_COLLECTOR_TIMESTAMP_EN
  assign out_ts       = head_vld ? head.ts     : '0;
`endif
  assign fill_level   = rst ? '0 : cnt;
  assign fatal_sticky = sticky & ~rst;
  assign irq_err      = out_valid | fatal_sticky;

endmodule
